sample_serializer: RTL and testbench
====================================

SAMPLE_SERIALIZER -- requirements
Module: sample_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = MSB shifted first, 0 = LSB first.
REQ-003 SHALL have port clkI  input  1  system clock (50 MHz), all logic on its rising edge.
REQ-004 SHALL have port rstnI  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port loadI  input  1  divided sample strobe; a rising edge requests one frame.
REQ-006 SHALL have port dataI  input  DATA_W  parallel sample from the phase accumulator / lookup path.
REQ-007 SHALL have port sdoO  output  1  serial data, one bit per clkI cycle.
REQ-008 SHALL have port csnO  output  1  frame select, low exactly while sdoO carries valid bits.
REQ-009 SHALL have port busyO  output  1  high from frame start through the gap cycle.
REQ-010 SHALL have port doneO  output  1  one-cycle pulse after the last bit.
REQ-011 SHALL have port overrunO  output  1  sticky flag for a load edge arriving while busy.

Function
REQ-012 SHALL register loadI into loadQ and detect edge = loadI & ~loadQ; loadQ resets to 1, so a high loadI at reset release starts no frame.
REQ-013 SHALL implement states IDLE, SHIFT, GAP.
REQ-014 IDLE + edge: on that clock edge SHALL capture dataI into shift register, drive first bit on sdoO, set csnO=0 and busyO=1, load bit counter with DATA_W-1, go to SHIFT.
REQ-015 SHIFT: each cycle SHALL present the next bit on sdoO (MSB/LSB order per MSB_FIRST) and decrement the counter; csnO low for exactly DATA_W consecutive cycles.
REQ-016 SHIFT, counter==0: next edge SHALL set csnO=1, sdoO=0, doneO=1 for one cycle, go to GAP.
REQ-017 GAP: one cycle, busyO=1, csnO=1; SHALL then return to IDLE; minimum frame-to-frame spacing DATA_W+1 cycles (17 at default, leaving 2 spare in a 19-cycle sample period).
REQ-018 edge in SHIFT or GAP SHALL be ignored (no restart, no data change); the in-flight frame completes unchanged.
REQ-019 edge in the same cycle GAP returns to IDLE SHALL be treated as occurring in GAP (ignored).
REQ-020 dataI changes after capture SHALL NOT affect the frame in flight.
REQ-021 sdoO SHALL be 0 whenever csnO=1.

Reset
REQ-022 rstnI low SHALL immediately force state IDLE, sdoO=0, csnO=1, busyO=0, doneO=0, overrunO=0, loadQ=1, counter and shift register 0, including mid-frame.
REQ-023 after rstnI release, the first frame SHALL require a fresh 0->1 transition on loadI.

Configuration
REQ-024 macro SAMPLE_OVERRUN_DET_EN defined: overrunO SHALL set on any ignored edge per REQ-018/019 and hold until reset.
REQ-025 macro undefined: overrunO SHALL be constant 0 and no detection logic synthesized; all other behaviour identical.

Verification
REQ-026 DATA_W=16, MSB_FIRST=1, dataI=16'hA5C3, single loadI edge -> csnO low 16 cycles, sdoO = 1010010111000011, doneO one pulse on the cycle csnO rises.
REQ-027 MSB_FIRST=0, dataI=16'h0001 -> sdoO 1 on the first frame cycle, 0 for the remaining 15.
REQ-028 loadI driven by the 19-cycle divider strobe, dataI incrementing from 0 -> 10 back-to-back frames, each frame equal to the value captured at its start, csnO high 3 cycles between frames, overrunO=0.
REQ-029 second loadI edge 5 cycles into a frame, macro defined -> frame unchanged, no restart, overrunO=1 until reset; macro undefined -> overrunO stays 0.
REQ-030 rstnI asserted at bit 8 of a frame -> csnO=1, sdoO=0, busyO=0 immediately; loadI held high through release -> no frame until loadI goes low then high.

Source files
------------

// File: rtl/sample_serializer.sv
// Parallel-to-serial frame shifter: one DATA_W-bit sample per load edge, framed by csnO.
// Optional sticky overrun detection is built only when SAMPLE_OVERRUN_DET_EN is defined.
module sample_serializer #(
  parameter int DATA_W    = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clkI,
  input  logic              rstnI,
  input  logic              loadI,
  input  logic [DATA_W-1:0] dataI,
  output logic              sdoO,
  output logic              csnO,
  output logic              busyO,
  output logic              doneO,
  output logic              overrunO
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            state;
  logic              load_q;
  logic              load_edge;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;

  // load_q resets high so a strobe already high at reset release is not an edge
  assign load_edge = loadI & ~load_q;

  always_ff @(posedge clkI or negedge rstnI) begin
    if (!rstnI) begin
      state  <= IDLE;
      load_q <= 1'b1;
      cnt    <= '0;
      shreg  <= '0;
      sdoO   <= 1'b0;
      csnO   <= 1'b1;
      busyO  <= 1'b0;
      doneO  <= 1'b0;
    end else begin
      load_q <= loadI;
      doneO  <= 1'b0;
      case (state)
        IDLE: begin
          if (load_edge) begin
            // first bit goes out immediately; shreg keeps only the bits still to send
            sdoO  <= MSB_FIRST ? dataI[DATA_W-1] : dataI[0];
            shreg <= MSB_FIRST ? {dataI[DATA_W-2:0], 1'b0} : {1'b0, dataI[DATA_W-1:1]};
            cnt   <= CNT_W'(DATA_W-1);
            csnO  <= 1'b0;
            busyO <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            sdoO  <= 1'b0;
            csnO  <= 1'b1;
            doneO <= 1'b1;
            state <= GAP;
          end else begin
            sdoO  <= MSB_FIRST ? shreg[DATA_W-1] : shreg[0];
            shreg <= MSB_FIRST ? {shreg[DATA_W-2:0], 1'b0} : {1'b0, shreg[DATA_W-1:1]};
            cnt   <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          busyO <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SAMPLE_OVERRUN_DET_EN
  logic overrun;

  // any edge outside IDLE is dropped, including one landing on the GAP->IDLE cycle
  always_ff @(posedge clkI or negedge rstnI) begin
    if (!rstnI)
      overrun <= 1'b0;
    else if (load_edge && state != IDLE)
      overrun <= 1'b1;
  end

  assign overrunO = overrun;
`else
  assign overrunO = 1'b0;
`endif

endmodule

// File: tb/tb_sample_serializer.sv
// Bench for sample_serializer: MSB-first and LSB-first instances share stimulus;
// a negedge monitor rebuilds each frame and checks it against a queue of expected samples.
module tb_sample_serializer;

  localparam int DW = 16;
`ifdef SAMPLE_OVERRUN_DET_EN
  localparam logic OVR_EN = 1'b1;
`else
  localparam logic OVR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          load;
  logic [DW-1:0] data;
  logic sdo_m, csn_m, busy_m, done_m, ovr_m;
  logic sdo_l, csn_l, busy_l, done_l, ovr_l;

  always #5 clk = ~clk;

  sample_serializer #(.DATA_W(DW), .MSB_FIRST(1'b1)) u_msb (
    .clkI(clk), .rstnI(rstn), .loadI(load), .dataI(data),
    .sdoO(sdo_m), .csnO(csn_m), .busyO(busy_m), .doneO(done_m), .overrunO(ovr_m));

  sample_serializer #(.DATA_W(DW), .MSB_FIRST(1'b0)) u_lsb (
    .clkI(clk), .rstnI(rstn), .loadI(load), .dataI(data),
    .sdoO(sdo_l), .csnO(csn_l), .busyO(busy_l), .doneO(done_l), .overrunO(ovr_l));

  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] exp_m;
    logic [DW-1:0] exp_l;
  } vec_t;

  typedef struct {
    logic [DW-1:0] m;
    logic [DW-1:0] l;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   b2b      = 1'b0;
  int   b2b_frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rev(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = x[DW-1-i];
    return r;
  endfunction

  // edge is sampled on the second posedge; dataI is scrambled right after capture
  task automatic pulse(input logic [DW-1:0] d, input bit push,
                       input logic [DW-1:0] em, input logic [DW-1:0] el);
    exp_t e;
    @(posedge clk); #1 load = 1'b1; data = d;
    @(posedge clk); #1 load = 1'b0; data = DW'($urandom);
    if (push) begin
      e.m = em;
      e.l = el;
      q.push_back(e);
    end
  endtask

  // frame monitor
  logic [DW-1:0] cap_m, cap_l;
  int   run    = 0;
  int   hi_run = 0;
  logic prev_csn = 1'b1;

  always @(negedge clk) begin
    if (!rstn) begin
      run = 0; hi_run = 0; prev_csn = 1'b1;
    end else begin
      check("csn_match", {31'd0, csn_l}, {31'd0, csn_m});
      if (!csn_m) begin
        if (prev_csn) begin
          if (b2b && b2b_frames > 0) check("b2b_gap_len", hi_run, 3);
          if (b2b) b2b_frames++;
          run = 0;
        end
        cap_m = {cap_m[DW-2:0], sdo_m};
        cap_l = {cap_l[DW-2:0], sdo_l};
        run++;
        hi_run = 0;
        check("busy_in_frame", {31'd0, busy_m}, 1);
        check("done_in_frame", {31'd0, done_m}, 0);
      end else begin
        check("sdo_idle_m", {31'd0, sdo_m}, 0);
        check("sdo_idle_l", {31'd0, sdo_l}, 0);
        if (!prev_csn) begin
          check("frame_len", run, DW);
          check("done_pulse_m", {31'd0, done_m}, 1);
          check("done_pulse_l", {31'd0, done_l}, 1);
          check("busy_gap", {31'd0, busy_m}, 1);
          if (q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_frame: got %0h expected none at %0t", cap_m, $time);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("frame_msb", {16'd0, cap_m}, {16'd0, e.m});
            check("frame_lsb", {16'd0, cap_l}, {16'd0, e.l});
          end
        end else begin
          check("done_idle", {31'd0, done_m}, 0);
          if (hi_run == 1) check("busy_after_gap", {31'd0, busy_m}, 0);
        end
        hi_run++;
      end
      prev_csn = csn_m;
    end
  end

  vec_t tbl[6];

  initial begin
    tbl[0] = '{16'hA5C3, 16'hA5C3, 16'hC3A5};
    tbl[1] = '{16'h0001, 16'h0001, 16'h8000};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[3] = '{16'h0000, 16'h0000, 16'h0000};
    tbl[4] = '{16'h8000, 16'h8000, 16'h0001};
    tbl[5] = '{16'h1234, 16'h1234, 16'h2C48};

    rstn = 1'b0; load = 1'b0; data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_csn",  {31'd0, csn_m},  1);
    check("rst_sdo",  {31'd0, sdo_m},  0);
    check("rst_busy", {31'd0, busy_m}, 0);
    check("rst_done", {31'd0, done_m}, 0);
    check("rst_ovr",  {31'd0, ovr_m},  0);
    check("rst_csn_l", {31'd0, csn_l}, 1);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      pulse(tbl[i].data, 1'b1, tbl[i].exp_m, tbl[i].exp_l);
      repeat (20) @(posedge clk);
    end

    // strobe every 19 cycles, incrementing sample
    b2b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pulse(DW'(i), 1'b1, DW'(i), rev(DW'(i)));
      repeat (17) @(posedge clk);
    end
    repeat (5) @(posedge clk);
    b2b = 1'b0;
    #1;
    check("b2b_frames", b2b_frames, 10);
    check("b2b_ovr", {31'd0, ovr_m}, 0);

    // edge landing while GAP is active is dropped
    pulse(16'h5A5A, 1'b1, 16'h5A5A, rev(16'h5A5A));
    repeat (16) @(posedge clk);
    #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("gap_edge_ovr_m", {31'd0, ovr_m}, {31'd0, OVR_EN});
    check("gap_edge_ovr_l", {31'd0, ovr_l}, {31'd0, OVR_EN});
    check("gap_edge_idle", {31'd0, busy_m}, 0);
    rstn = 1'b0;
    #2 check("ovr_clear", {31'd0, ovr_m}, 0);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // second edge 5 cycles into a frame
    pulse(16'h3C96, 1'b1, 16'h3C96, rev(16'h3C96));
    repeat (4) @(posedge clk);
    pulse(16'hFFFF, 1'b0, '0, '0);
    repeat (20) @(posedge clk);
    #1 check("shift_edge_ovr", {31'd0, ovr_m}, {31'd0, OVR_EN});
    pulse(16'h0F0F, 1'b1, 16'h0F0F, rev(16'h0F0F));
    repeat (20) @(posedge clk);
    #1 check("ovr_sticky", {31'd0, ovr_m}, {31'd0, OVR_EN});

    // reset mid-frame with load held high through release
    pulse(16'hBEEF, 1'b1, 16'hBEEF, rev(16'hBEEF));
    repeat (8) @(posedge clk);
    #1 rstn = 1'b0; load = 1'b1;
    #1;
    check("abort_csn",  {31'd0, csn_m},  1);
    check("abort_sdo",  {31'd0, sdo_m},  0);
    check("abort_busy", {31'd0, busy_m}, 0);
    check("abort_ovr",  {31'd0, ovr_m},  0);
    q.delete();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("held_load_busy", {31'd0, busy_m}, 0);
    check("held_load_csn",  {31'd0, csn_m},  1);
    load = 1'b0;
    @(posedge clk);
    pulse(16'h6D2B, 1'b1, 16'h6D2B, rev(16'h6D2B));
    repeat (20) @(posedge clk);
    #1;
    check("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
